frame_writer: RTL and testbench

- Upstream drawing stage for the LED panel display block.
- Accepts drawing commands from the MCU command deserializer through a valid/ready handshake: clear, single pixel, or filled rectangle.
- Rasterizes each command into one pixel write per clock on the display's memory-write interface (write_en/write_x/write_y/write_color).
- Clips every command to the 64x64 panel, so the pixel memory never sees an out-of-range address.

---
 rtl/frame_writer_pkg.sv | 31 +++
 rtl/frame_writer_rect_clip.sv | 55 +++++
 rtl/frame_writer.sv | 158 +++++++++++++++
 tb/tb_frame_writer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_writer_pkg.sv
// Shared definitions for the LED panel drawing path: panel geometry, command
// opcodes and the frame writer state encoding.
package frame_writer_pkg;

  localparam int PANEL_W = 64;
  localparam int PANEL_H = 64;
  localparam int XW      = 6;
  localparam int YW      = 6;
  localparam int CW      = 12;

  // Lengths carry one extra bit so a full 64-pixel span is representable.
  localparam int LW = ((XW > YW) ? XW : YW) + 1;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_CLEAR = 2'd1,
    OP_PIXEL = 2'd2,
    OP_RECT  = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DRAW = 1'b1
  } state_e;

  function automatic logic [LW-1:0] clipLen(input logic [LW-1:0] len,
                                            input logic [LW-1:0] room);
    return (len < room) ? len : room;
  endfunction

endpackage

// File: rtl/frame_writer_rect_clip.sv
// Combinational command normaliser: expands CLEAR/PIXEL into rectangle form and
// clips the span so it never runs past the right or bottom panel edge.
module rect_clip
  import frame_writer_pkg::*;
(
  input  logic [1:0]    i_op,
  input  logic [XW-1:0] i_x0,
  input  logic [YW-1:0] i_y0,
  input  logic [XW:0]   i_w,
  input  logic [YW:0]   i_h,
  output logic [XW-1:0] o_x0,
  output logic [YW-1:0] o_y0,
  output logic [XW:0]   o_wEff,
  output logic [YW:0]   o_hEff,
  output logic          o_zeroArea
);

  logic [XW-1:0] w_x0Norm;
  logic [YW-1:0] w_y0Norm;
  logic [XW:0]   w_wNorm;
  logic [YW:0]   w_hNorm;
  logic [LW-1:0] w_xRoom;
  logic [LW-1:0] w_yRoom;

  always_comb begin
    w_x0Norm = i_x0;
    w_y0Norm = i_y0;
    w_wNorm  = i_w;
    w_hNorm  = i_h;
    case (i_op)
      OP_CLEAR: begin
        w_x0Norm = '0;
        w_y0Norm = '0;
        w_wNorm  = (XW+1)'(PANEL_W);
        w_hNorm  = (YW+1)'(PANEL_H);
      end
      OP_PIXEL: begin
        w_wNorm = (XW+1)'(1);
        w_hNorm = (YW+1)'(1);
      end
      default: ;
    endcase
  end

  // Room to the panel edge is always 1..64, so it never underflows.
  assign w_xRoom = LW'(PANEL_W) - LW'(w_x0Norm);
  assign w_yRoom = LW'(PANEL_H) - LW'(w_y0Norm);

  assign o_x0       = w_x0Norm;
  assign o_y0       = w_y0Norm;
  assign o_wEff     = (XW+1)'(clipLen(LW'(w_wNorm), w_xRoom));
  assign o_hEff     = (YW+1)'(clipLen(LW'(w_hNorm), w_yRoom));
  assign o_zeroArea = (o_wEff == '0) || (o_hEff == '0);

endmodule

// File: rtl/frame_writer.sv
// Drawing-command rasterizer for the LED panel: accepts one command at a time
// and emits one clipped pixel write per clock in x-inner, y-outer order.
module frame_writer
  import frame_writer_pkg::*;
(
  input  logic          clk_in,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [XW-1:0] cmd_x0,
  input  logic [YW-1:0] cmd_y0,
  input  logic [XW:0]   cmd_w,
  input  logic [YW:0]   cmd_h,
  input  logic [CW-1:0] cmd_color,
  output logic          write_en,
  output logic [XW-1:0] write_x,
  output logic [YW-1:0] write_y,
  output logic [CW-1:0] write_color,
  output logic          busy,
  output logic          cmd_done
);

  localparam logic [XW:0] X_ONE = (XW+1)'(1);
  localparam logic [YW:0] Y_ONE = (YW+1)'(1);

  state_e        r_state;
  state_e        w_stateNext;

  logic [XW:0]   r_xCnt, w_xNext;
  logic [YW:0]   r_yCnt, w_yNext;
  logic [XW:0]   r_x0, w_x0Next;
  logic [XW:0]   r_xLast, w_xLastNext;
  logic [YW:0]   r_yLast, w_yLastNext;
  logic [CW-1:0] r_color, w_colorNext;
  logic          r_writeEn, w_writeEnNext;
  logic          r_busy, w_busyNext;
  logic          r_done, w_doneNext;

  logic [XW-1:0] w_clipX0;
  logic [YW-1:0] w_clipY0;
  logic [XW:0]   w_wEff;
  logic [YW:0]   w_hEff;
  logic          w_zeroArea;
  logic          w_accept;
  logic          w_rowEnd;

  rect_clip u_rectClip (
    .i_op       (cmd_op),
    .i_x0       (cmd_x0),
    .i_y0       (cmd_y0),
    .i_w        (cmd_w),
    .i_h        (cmd_h),
    .o_x0       (w_clipX0),
    .o_y0       (w_clipY0),
    .o_wEff     (w_wEff),
    .o_hEff     (w_hEff),
    .o_zeroArea (w_zeroArea)
  );

  assign cmd_ready = (r_state == ST_IDLE);
  assign w_accept  = cmd_valid && cmd_ready && (cmd_op != OP_NOP);
  assign w_rowEnd  = (r_xCnt == r_xLast);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // The first pixel is registered at the accept edge; each DRAW edge advances
  // to the next pixel until the one flagged done has been presented.
  always_comb begin
    w_stateNext   = r_state;
    w_xNext       = r_xCnt;
    w_yNext       = r_yCnt;
    w_x0Next      = r_x0;
    w_xLastNext   = r_xLast;
    w_yLastNext   = r_yLast;
    w_colorNext   = r_color;
    w_writeEnNext = 1'b0;
    w_busyNext    = 1'b0;
    w_doneNext    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_stateNext = ST_DRAW;
          w_busyNext  = 1'b1;
          if (w_zeroArea) begin
            w_doneNext = 1'b1;
          end else begin
            w_writeEnNext = 1'b1;
            w_xNext       = {1'b0, w_clipX0};
            w_yNext       = {1'b0, w_clipY0};
            w_x0Next      = {1'b0, w_clipX0};
            w_xLastNext   = {1'b0, w_clipX0} + w_wEff - X_ONE;
            w_yLastNext   = {1'b0, w_clipY0} + w_hEff - Y_ONE;
            w_colorNext   = cmd_color;
            w_doneNext    = (w_wEff == X_ONE) && (w_hEff == Y_ONE);
          end
        end
      end
      ST_DRAW: begin
        if (r_done) begin
          w_stateNext = ST_IDLE;
        end else begin
          w_busyNext    = 1'b1;
          w_writeEnNext = 1'b1;
          if (w_rowEnd) begin
            w_xNext = r_x0;
            w_yNext = r_yCnt + Y_ONE;
          end else begin
            w_xNext = r_xCnt + X_ONE;
          end
          w_doneNext = (w_xNext == r_xLast) && (w_yNext == r_yLast);
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Coordinates and colour only move on a real write, so they hold otherwise.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_xCnt    <= '0;
      r_yCnt    <= '0;
      r_x0      <= '0;
      r_xLast   <= '0;
      r_yLast   <= '0;
      r_color   <= '0;
      r_writeEn <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_xCnt    <= w_xNext;
      r_yCnt    <= w_yNext;
      r_x0      <= w_x0Next;
      r_xLast   <= w_xLastNext;
      r_yLast   <= w_yLastNext;
      r_color   <= w_colorNext;
      r_writeEn <= w_writeEnNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
    end
  end

  assign write_en    = r_writeEn;
  assign write_x     = r_xCnt[XW-1:0];
  assign write_y     = r_yCnt[YW-1:0];
  assign write_color = r_color;
  assign busy        = r_busy;
  assign cmd_done    = r_done;

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer: a per-command pixel-list model is
// compared against the DUT every cycle, alongside directed literal checks.
module tb_frame_writer;
  import frame_writer_pkg::*;

  logic        clk_in    = 1'b0;
  logic        reset     = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op    = 2'd0;
  logic [5:0]  cmd_x0    = '0;
  logic [5:0]  cmd_y0    = '0;
  logic [6:0]  cmd_w     = '0;
  logic [6:0]  cmd_h     = '0;
  logic [11:0] cmd_color = '0;
  logic        cmd_ready;
  logic        write_en;
  logic [5:0]  write_x;
  logic [5:0]  write_y;
  logic [11:0] write_color;
  logic        busy;
  logic        cmd_done;

  int checkCount = 0;
  int passCount  = 0;
  bit cmpEnable  = 1'b0;

  frame_writer dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_x0      (cmd_x0),
    .cmd_y0      (cmd_y0),
    .cmd_w       (cmd_w),
    .cmd_h       (cmd_h),
    .cmd_color   (cmd_color),
    .write_en    (write_en),
    .write_x     (write_x),
    .write_y     (write_y),
    .write_color (write_color),
    .busy        (busy),
    .cmd_done    (cmd_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: each accepted command becomes the full list of output cycles it
  // must produce; one entry is retired per clock edge.
  typedef struct {
    logic        en;
    logic [5:0]  x;
    logic [5:0]  y;
    logic [11:0] c;
    logic        done;
  } cyc_t;

  cyc_t        pending[$];
  logic [5:0]  heldX = '0;
  logic [5:0]  heldY = '0;
  logic [11:0] heldC = '0;

  task automatic modelAccept();
    int x0, y0, w, h, we, he;
    x0 = int'(cmd_x0);
    y0 = int'(cmd_y0);
    w  = int'(cmd_w);
    h  = int'(cmd_h);
    if (cmd_op == 2'd1) begin
      x0 = 0; y0 = 0; w = 64; h = 64;
    end else if (cmd_op == 2'd2) begin
      w = 1; h = 1;
    end
    we = (w < 64 - x0) ? w : 64 - x0;
    he = (h < 64 - y0) ? h : 64 - y0;
    if (we == 0 || he == 0) begin
      pending.push_back('{1'b0, heldX, heldY, heldC, 1'b1});
    end else begin
      for (int yy = y0; yy < y0 + he; yy++)
        for (int xx = x0; xx < x0 + we; xx++)
          pending.push_back('{1'b1, 6'(xx), 6'(yy), cmd_color,
                              (xx == x0 + we - 1) && (yy == y0 + he - 1)});
      heldX = 6'(x0 + we - 1);
      heldY = 6'(y0 + he - 1);
      heldC = cmd_color;
    end
  endtask

  always @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pending.delete();
      heldX = '0;
      heldY = '0;
      heldC = '0;
    end else if (pending.size() != 0) begin
      void'(pending.pop_front());
    end else if (cmd_valid && cmd_op != 2'd0) begin
      modelAccept();
    end
  end

  cyc_t expCyc;
  logic expBusy;

  always @(negedge clk_in) begin
    if (cmpEnable) begin
      if (pending.size() != 0) begin
        expCyc  = pending[0];
        expBusy = 1'b1;
      end else begin
        expCyc  = '{1'b0, heldX, heldY, heldC, 1'b0};
        expBusy = 1'b0;
      end
      checkOutput("cmd_ready", cmd_ready, !expBusy);
      checkOutput("busy", busy, expBusy);
      checkOutput("write_en", write_en, expCyc.en);
      checkOutput("cmd_done", cmd_done, expCyc.done);
      checkOutput("write_x", write_x, expCyc.x);
      checkOutput("write_y", write_y, expCyc.y);
      checkOutput("write_color", write_color, expCyc.c);
    end
  end

  // Presents a command at a falling edge and returns just after its accept edge.
  task automatic applyStimulus(input logic [1:0] op, input int x0, input int y0,
                               input int w, input int h, input int color,
                               input bit hold, output int waited);
    @(negedge clk_in);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x0    = 6'(x0);
    cmd_y0    = 6'(y0);
    cmd_w     = 7'(w);
    cmd_h     = 7'(h);
    cmd_color = 12'(color);
    waited    = 0;
    while (!cmd_ready && waited < 10000) begin
      @(negedge clk_in);
      waited++;
    end
    if (!cmd_ready) begin
      checkOutput("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk_in);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk_in);
    cmd_valid = 1'b0;
    while (!cmd_ready && n < 10000) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput("idle_timeout", cmd_ready, 1);
  endtask

  initial begin
    int wt;
    int rx[4] = '{62, 63, 62, 63};
    int ry[4] = '{5, 5, 6, 6};
    int nW, doneCnt, doneIdx, firstXY, lastXY, stray;
    logic [1:0] op;
    int x0, y0, w, h;
    bit hold;

    #1 reset = 1'b1;
    #2;
    checkOutput("reset_ready", cmd_ready, 1);
    checkOutput("reset_write_en", write_en, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", cmd_done, 0);
    checkOutput("reset_xy", {write_x, write_y}, 0);
    repeat (3) @(negedge clk_in);
    #2 reset = 1'b0;
    cmpEnable = 1'b1;

    $display("[TB] single pixel");
    applyStimulus(2'd2, 10, 20, 0, 0, 12'hF00, 1'b0, wt);
    @(negedge clk_in);
    checkOutput("pix_en", write_en, 1);
    checkOutput("pix_x", write_x, 10);
    checkOutput("pix_y", write_y, 20);
    checkOutput("pix_color", write_color, 12'hF00);
    checkOutput("pix_done", cmd_done, 1);
    @(negedge clk_in);
    checkOutput("pix_ready_after", cmd_ready, 1);
    checkOutput("pix_en_after", write_en, 0);

    $display("[TB] clipped rectangle");
    applyStimulus(2'd3, 62, 5, 4, 2, 12'h0A5, 1'b0, wt);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      checkOutput("rect_en", write_en, 1);
      checkOutput("rect_x", write_x, rx[i]);
      checkOutput("rect_y", write_y, ry[i]);
      checkOutput("rect_done", cmd_done, (i == 3));
    end
    @(negedge clk_in);
    checkOutput("rect_en_after", write_en, 0);

    $display("[TB] full clear");
    applyStimulus(2'd1, 17, 9, 3, 3, 12'h000, 1'b0, wt);
    nW = 0; doneCnt = 0; doneIdx = -1; firstXY = -1; lastXY = -1;
    for (int i = 0; i < 4200; i++) begin
      @(negedge clk_in);
      if (write_en) begin
        if (nW == 0) firstXY = int'(write_y) * 64 + int'(write_x);
        lastXY = int'(write_y) * 64 + int'(write_x);
        nW++;
        if (cmd_done) begin
          doneCnt++;
          doneIdx = nW;
        end
      end
      if (cmd_ready) break;
    end
    checkOutput("clear_count", nW, 4096);
    checkOutput("clear_first", firstXY, 0);
    checkOutput("clear_last", lastXY, 4095);
    checkOutput("clear_done_count", doneCnt, 1);
    checkOutput("clear_done_index", doneIdx, 4096);

    $display("[TB] zero-area rectangle");
    applyStimulus(2'd3, 3, 4, 0, 7, 12'h123, 1'b0, wt);
    @(negedge clk_in);
    checkOutput("zero_en", write_en, 0);
    checkOutput("zero_done", cmd_done, 1);
    checkOutput("zero_busy", busy, 1);
    checkOutput("zero_ready", cmd_ready, 0);
    @(negedge clk_in);
    checkOutput("zero_ready_after", cmd_ready, 1);
    checkOutput("zero_done_after", cmd_done, 0);

    $display("[TB] back-to-back commands");
    applyStimulus(2'd2, 1, 1, 0, 0, 12'h0F0, 1'b1, wt);
    applyStimulus(2'd3, 0, 0, 2, 1, 12'h00F, 1'b1, wt);
    checkOutput("b2b_handshake_wait", wt, 1);
    applyStimulus(2'd0, 5, 5, 5, 5, 12'hFFF, 1'b0, wt);
    checkOutput("nop_wait", wt, 2);
    @(negedge clk_in);
    checkOutput("nop_en", write_en, 0);
    checkOutput("nop_busy", busy, 0);

    $display("[TB] reset during clear");
    applyStimulus(2'd1, 0, 0, 0, 0, 12'h777, 1'b0, wt);
    repeat (100) @(negedge clk_in);
    checkOutput("w100_x", write_x, 35);
    checkOutput("w100_y", write_y, 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("abort_en", write_en, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", cmd_done, 0);
    @(negedge clk_in);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_ready", cmd_ready, 1);
    stray = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (write_en) stray++;
    end
    checkOutput("abort_residual_writes", stray, 0);

    $display("[TB] randomized commands");
    for (int n = 0; n < 80; n++) begin
      op = 2'($urandom_range(0, 3));
      if (op == 2'd1 && $urandom_range(0, 9) != 0) op = 2'd3;
      x0 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(54, 63)) : int'($urandom_range(0, 63));
      y0 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(58, 63)) : int'($urandom_range(0, 63));
      w  = ($urandom_range(0, 7) == 0) ? 64 : int'($urandom_range(0, 12));
      h  = ($urandom_range(0, 7) == 0) ? 64 : int'($urandom_range(0, 5));
      hold = ($urandom_range(0, 1) != 0);
      applyStimulus(op, x0, y0, w, h, int'($urandom_range(0, 4095)), hold, wt);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk_in);
    end
    waitIdle();
    repeat (3) @(negedge clk_in);
    cmpEnable = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
